// File: rtl/copper_mem32_pkg.sv
// Shared types and constants for the copper program memory.
// Holds the arbiter state encoding and the power-up image.
package copper_mem32_pkg;

    localparam int COPP_AWIDTH      = 10;
    localparam int COPP_INFO_OFFSET = 2**COPP_AWIDTH - 16;

    localparam logic [15:0] XOSERA_VERSION = 16'h0100;
    localparam bit          GITCLEAN       = 1'b0;
    localparam logic [31:0] GITHASH        = 32'h1C0FFEE5;

    localparam logic [15:0] COP_WAIT = 16'h2FFF;
    localparam logic [31:0] COP_BOOT = 32'h0800FF81;

    localparam int                  INFO_LEN  = 24;
    localparam logic [8*INFO_LEN-1:0] INFO_TEXT = "Xosera copper mem32 v1.0";

    typedef logic [31:0] copper_long_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DATA
    } arb_state_t;

    // byte k of the info text, zero past its end
    function automatic logic [7:0] info_byte(int k);
        logic [8*INFO_LEN-1:0] t;
        if (k < 0 || k >= INFO_LEN) begin
            return 8'h00;
        end
        t = INFO_TEXT >> (8 * (INFO_LEN - 1 - k));
        return t[7:0];
    endfunction

    // power-up longword at index idx: boot program, info block, else wait
    function automatic copper_long_t init_long(int idx, int info_offset,
                                               bit en_info);
        int           rel;
        copper_long_t v;
        v   = {COP_WAIT, COP_WAIT};
        if (idx == 0) begin
            v = COP_BOOT;
        end
        rel = idx - info_offset;
        if (en_info && rel >= 0 && rel < 16) begin
            if (rel == 14) begin
                v = {XOSERA_VERSION, GITCLEAN ? 16'h0000 : 16'h0100};
            end else if (rel == 15) begin
                v = GITHASH;
            end else begin
                v = {info_byte(4*rel),     info_byte(4*rel + 1),
                     info_byte(4*rel + 2), info_byte(4*rel + 3)};
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/copper_bank.sv
// One 16-bit half of the copper program memory.
// Single write port, single asynchronous read port.
module copper_bank
    import copper_mem32_pkg::*;
#(
    parameter int AWIDTH      = COPP_AWIDTH,
    parameter bit EN_INFO     = 1'b1,
    parameter int INFO_OFFSET = 2**AWIDTH - 16,
    parameter bit ODDWORD     = 1'b0
)(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [15:0]       rd_data
);

    localparam int DEPTH = 2**AWIDTH;

    // The array stores the difference from the preload image, so a
    // zero power-up array reads back the image without an init pass.
    logic [15:0] mem [DEPTH];

    function automatic logic [15:0] image_word(logic [AWIDTH-1:0] a);
        copper_long_t l;
        l = init_long(int'(a), INFO_OFFSET, EN_INFO);
        return ODDWORD ? l[15:0] : l[31:16];
    endfunction

    // host write commits at the clock edge
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data ^ image_word(wr_addr);
        end
    end

    assign rd_data = mem[rd_addr] ^ image_word(rd_addr);

endmodule

// File: rtl/copper_mem32.sv
// Copper program memory: even/odd 16-bit banks, host read arbiter,
// write-first forwarding and registered copper/host outputs.
module copper_mem32
    import copper_mem32_pkg::*;
#(
    parameter int AWIDTH       = COPP_AWIDTH,
    parameter bit EN_INFO      = 1'b1,
    parameter int INFO_OFFSET  = 2**AWIDTH - 16,
    parameter int STARVE_LIMIT = 7
)(
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              cop_rd_en_i,
    input  logic [AWIDTH-1:0] cop_rd_addr_i,
    output logic [31:0]       cop_rd_data_o,
    output logic              cop_rd_valid_o,
    input  logic              host_wr_en_i,
    input  logic [AWIDTH:0]   host_addr_i,
    input  logic [15:0]       host_wr_data_i,
    input  logic              host_rd_req_i,
    output logic [15:0]       host_rd_data_o,
    output logic              host_rd_ack_o
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t        arb_state;
    logic [3:0]        starve_cnt;
    logic              host_gnt;
    logic              cop_gnt;
    logic [AWIDTH-1:0] host_idx;
    logic              host_odd;
    logic [AWIDTH-1:0] rd_idx;
    logic              wr_even;
    logic              wr_odd;
    logic [15:0]       even_rd;
    logic [15:0]       odd_rd;
    logic [15:0]       even_word;
    logic [15:0]       odd_word;
    logic [15:0]       host_word;

    assign host_idx = host_addr_i[AWIDTH:1];
    assign host_odd = host_addr_i[0];

    assign host_gnt = (arb_state == WAIT) && host_rd_req_i &&
                      (!cop_rd_en_i || starve_cnt == STARVE_MAX);
    assign cop_gnt  = cop_rd_en_i && !host_gnt;

    assign rd_idx  = host_gnt ? host_idx : cop_rd_addr_i;
    assign wr_even = host_wr_en_i && !host_odd;
    assign wr_odd  = host_wr_en_i && host_odd;

    assign even_word = (wr_even && host_idx == rd_idx) ?
                       host_wr_data_i : even_rd;
    assign odd_word  = (wr_odd && host_idx == rd_idx) ?
                       host_wr_data_i : odd_rd;
    assign host_word = host_odd ? odd_word : even_word;

    copper_bank #(
        .AWIDTH     (AWIDTH),
        .EN_INFO    (EN_INFO),
        .INFO_OFFSET(INFO_OFFSET),
        .ODDWORD    (1'b0)
    ) u_even (
        .clk    (clk),
        .wr_en  (wr_even),
        .wr_addr(host_idx),
        .wr_data(host_wr_data_i),
        .rd_addr(rd_idx),
        .rd_data(even_rd)
    );

    copper_bank #(
        .AWIDTH     (AWIDTH),
        .EN_INFO    (EN_INFO),
        .INFO_OFFSET(INFO_OFFSET),
        .ODDWORD    (1'b1)
    ) u_odd (
        .clk    (clk),
        .wr_en  (wr_odd),
        .wr_addr(host_idx),
        .wr_data(host_wr_data_i),
        .rd_addr(rd_idx),
        .rd_data(odd_rd)
    );

    // copper fetch result, valid only when the port was not stolen
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cop_rd_data_o  <= '0;
            cop_rd_valid_o <= 1'b0;
        end else begin
            cop_rd_valid_o <= cop_gnt;
            if (cop_gnt) begin
                cop_rd_data_o <= {even_word, odd_word};
            end
        end
    end

    // host read arbiter with starvation-bounded wait and one-cycle ack
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            arb_state      <= IDLE;
            starve_cnt     <= '0;
            host_rd_data_o <= '0;
            host_rd_ack_o  <= 1'b0;
        end else begin
            host_rd_ack_o <= 1'b0;
            unique case (arb_state)
                IDLE: begin
                    if (host_rd_req_i) begin
                        arb_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!host_rd_req_i) begin
                        arb_state  <= IDLE;
                        starve_cnt <= '0;
                    end else if (host_gnt) begin
                        arb_state      <= DATA;
                        starve_cnt     <= '0;
                        host_rd_ack_o  <= 1'b1;
                        host_rd_data_o <= host_word;
                    end else begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                DATA: begin
                    arb_state <= IDLE;
                end
                default: begin
                    arb_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_copper_mem32.sv
// Self-checking bench for copper_mem32.
// Scoreboard queues hold expected copper and host results.
module tb_copper_mem32;
    import copper_mem32_pkg::*;

    localparam int AW           = COPP_AWIDTH;
    localparam int INFO_OFF     = 2**AW - 16;
    localparam int STARVE_LIMIT = 7;

    typedef struct {
        bit          valid;
        logic [31:0] data;
    } cop_exp_t;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          cop_rd_en_i;
    logic [AW-1:0] cop_rd_addr_i;
    logic [31:0]   cop_rd_data_o;
    logic          cop_rd_valid_o;
    logic          host_wr_en_i;
    logic [AW:0]   host_addr_i;
    logic [15:0]   host_wr_data_i;
    logic          host_rd_req_i;
    logic [15:0]   host_rd_data_o;
    logic          host_rd_ack_o;

    cop_exp_t      cop_q[$];
    logic [15:0]   host_q[$];
    int            errors = 0;
    int            checks = 0;

    copper_mem32 #(
        .AWIDTH      (AW),
        .EN_INFO     (1'b1),
        .INFO_OFFSET (INFO_OFF),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk           (clk),
        .reset_n_i     (reset_n_i),
        .cop_rd_en_i   (cop_rd_en_i),
        .cop_rd_addr_i (cop_rd_addr_i),
        .cop_rd_data_o (cop_rd_data_o),
        .cop_rd_valid_o(cop_rd_valid_o),
        .host_wr_en_i  (host_wr_en_i),
        .host_addr_i   (host_addr_i),
        .host_wr_data_i(host_wr_data_i),
        .host_rd_req_i (host_rd_req_i),
        .host_rd_data_o(host_rd_data_o),
        .host_rd_ack_o (host_rd_ack_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_n_i      = 1'b0;
        cop_rd_en_i    = 1'b0;
        cop_rd_addr_i  = '0;
        host_wr_en_i   = 1'b0;
        host_addr_i    = '0;
        host_wr_data_i = '0;
        host_rd_req_i  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cop_rd_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_cop_data: got %h want 0", cop_rd_data_o);
        end
        checks++;
        if (cop_rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_cop_valid: got %b want 0", cop_rd_valid_o);
        end
        checks++;
        if (host_rd_data_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_host_data: got %h want 0", host_rd_data_o);
        end
        checks++;
        if (host_rd_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_host_ack: got %b want 0", host_rd_ack_o);
        end
        reset_n_i = 1'b1;
    endtask

    task automatic test_info();
        logic [AW-1:0] addrs [4];
        logic [31:0]   exps  [4];
        cop_exp_t      e;
        addrs[0] = AW'(INFO_OFF + 14);
        exps[0]  = {XOSERA_VERSION, GITCLEAN ? 16'h0000 : 16'h0100};
        addrs[1] = '0;
        exps[1]  = 32'h0800FF81;
        addrs[2] = AW'(INFO_OFF + 15);
        exps[2]  = GITHASH;
        addrs[3] = AW'(INFO_OFF);
        exps[3]  = 32'h586F7365;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cop_rd_en_i   = 1'b1;
            cop_rd_addr_i = addrs[i];
            cop_q.push_back('{1'b1, exps[i]});
            @(negedge clk);
            e = cop_q.pop_front();
            checks++;
            if (cop_rd_valid_o !== e.valid || cop_rd_data_o !== e.data) begin
                errors++;
                $display("FAIL info_fetch[%0d]: got v=%b %h want v=%b %h",
                         i, cop_rd_valid_o, cop_rd_data_o, e.valid, e.data);
            end
        end
        cop_rd_en_i = 1'b0;
    endtask

    task automatic test_write_fetch();
        cop_exp_t e;
        @(negedge clk);
        host_wr_en_i   = 1'b1;
        host_addr_i    = (AW+1)'(6);
        host_wr_data_i = 16'h1234;
        @(negedge clk);
        host_addr_i    = (AW+1)'(7);
        host_wr_data_i = 16'hABCD;
        @(negedge clk);
        host_wr_en_i  = 1'b0;
        cop_rd_en_i   = 1'b1;
        cop_rd_addr_i = AW'(3);
        cop_q.push_back('{1'b1, 32'h1234ABCD});
        @(negedge clk);
        cop_rd_en_i = 1'b0;
        e = cop_q.pop_front();
        checks++;
        if (cop_rd_valid_o !== e.valid || cop_rd_data_o !== e.data) begin
            errors++;
            $display("FAIL write_fetch: got v=%b %h want v=%b %h",
                     cop_rd_valid_o, cop_rd_data_o, e.valid, e.data);
        end
        @(negedge clk);
        checks++;
        if (cop_rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle_valid: got %b want 0", cop_rd_valid_o);
        end
    endtask

    task automatic test_host_read();
        int          lat;
        int          extra;
        bit          got;
        logic [15:0] d;
        logic [15:0] x;
        @(negedge clk);
        host_addr_i   = (AW+1)'(7);
        host_rd_req_i = 1'b1;
        host_q.push_back(16'hABCD);
        lat = 0;
        got = 1'b0;
        d   = '0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (host_rd_ack_o === 1'b1) begin
                got = 1'b1;
                d   = host_rd_data_o;
            end
        end
        host_rd_req_i = 1'b0;
        checks++;
        if (!got || lat != 2) begin
            errors++;
            $display("FAIL host_read_latency: got %0d (ack=%b) want 2",
                     lat, got);
        end
        x = host_q.pop_front();
        checks++;
        if (d !== x) begin
            errors++;
            $display("FAIL host_read_data: got %h want %h", d, x);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (host_rd_ack_o !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL host_read_single_ack: got %0d extra want 0", extra);
        end
    endtask

    task automatic test_forward();
        logic [AW:0]  waddr [3];
        logic [15:0]  wdata [3];
        logic [31:0]  exps  [3];
        cop_exp_t     e;
        waddr[0] = (AW+1)'(6);
        wdata[0] = 16'h5555;
        exps[0]  = 32'h5555ABCD;
        waddr[1] = (AW+1)'(7);
        wdata[1] = 16'h7777;
        exps[1]  = 32'h55557777;
        waddr[2] = (AW+1)'(7);
        wdata[2] = 16'hABCD;
        exps[2]  = 32'h5555ABCD;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            host_wr_en_i   = 1'b1;
            host_addr_i    = waddr[i];
            host_wr_data_i = wdata[i];
            cop_rd_en_i    = 1'b1;
            cop_rd_addr_i  = AW'(3);
            cop_q.push_back('{1'b1, exps[i]});
            @(negedge clk);
            e = cop_q.pop_front();
            checks++;
            if (cop_rd_valid_o !== e.valid || cop_rd_data_o !== e.data) begin
                errors++;
                $display("FAIL forward[%0d]: got v=%b %h want v=%b %h",
                         i, cop_rd_valid_o, cop_rd_data_o, e.valid, e.data);
            end
        end
        host_wr_en_i = 1'b0;
        cop_rd_en_i  = 1'b0;
    endtask

    task automatic test_starve();
        cop_exp_t    e;
        int          ack_cnt;
        int          ack_j;
        logic [15:0] ack_data;
        logic [15:0] x;
        @(negedge clk);
        host_addr_i   = (AW+1)'(7);
        host_rd_req_i = 1'b1;
        host_q.push_back(16'hABCD);
        ack_cnt  = 0;
        ack_j    = 0;
        ack_data = '0;
        for (int j = 1; j <= 14; j++) begin
            cop_rd_en_i   = 1'b1;
            cop_rd_addr_i = ((j % 2) != 0) ? AW'(3) : AW'(0);
            cop_q.push_back('{(j != STARVE_LIMIT + 2),
                              ((j % 2) != 0) ? 32'h5555ABCD : 32'h0800FF81});
            @(negedge clk);
            e = cop_q.pop_front();
            checks++;
            if (cop_rd_valid_o !== e.valid ||
                (e.valid && cop_rd_data_o !== e.data)) begin
                errors++;
                $display("FAIL starve_fetch[%0d]: got v=%b %h want v=%b %h",
                         j, cop_rd_valid_o, cop_rd_data_o, e.valid, e.data);
            end
            if (host_rd_ack_o === 1'b1) begin
                ack_cnt++;
                ack_j         = j;
                ack_data      = host_rd_data_o;
                host_rd_req_i = 1'b0;
            end
        end
        cop_rd_en_i   = 1'b0;
        host_rd_req_i = 1'b0;
        checks++;
        if (ack_cnt != 1 || ack_j != STARVE_LIMIT + 2) begin
            errors++;
            $display("FAIL starve_ack: got %0d acks at %0d want 1 at %0d",
                     ack_cnt, ack_j, STARVE_LIMIT + 2);
        end
        x = host_q.pop_front();
        checks++;
        if (ack_data !== x) begin
            errors++;
            $display("FAIL starve_data: got %h want %h", ack_data, x);
        end
    endtask

    task automatic test_req_drop();
        cop_exp_t e;
        int       acks;
        int       bad;
        acks = 0;
        bad  = 0;
        @(negedge clk);
        host_addr_i   = (AW+1)'(7);
        host_rd_req_i = 1'b1;
        for (int j = 0; j < 12; j++) begin
            cop_rd_en_i   = 1'b1;
            cop_rd_addr_i = AW'(0);
            cop_q.push_back('{1'b1, 32'h0800FF81});
            @(negedge clk);
            host_rd_req_i = 1'b0;
            e = cop_q.pop_front();
            if (cop_rd_valid_o !== e.valid || cop_rd_data_o !== e.data) bad++;
            if (host_rd_ack_o !== 1'b0) acks++;
        end
        cop_rd_en_i = 1'b0;
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL req_drop_ack: got %0d acks want 0", acks);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL req_drop_fetch: got %0d bad fetches want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        cop_exp_t e;
        int       acks;
        @(negedge clk);
        cop_rd_en_i   = 1'b1;
        cop_rd_addr_i = AW'(3);
        cop_q.push_back('{1'b1, 32'h5555ABCD});
        @(negedge clk);
        cop_rd_en_i = 1'b0;
        e = cop_q.pop_front();
        checks++;
        if (cop_rd_valid_o !== e.valid || cop_rd_data_o !== e.data) begin
            errors++;
            $display("FAIL pre_reset_fetch: got %h want %h",
                     cop_rd_data_o, e.data);
        end
        host_addr_i   = (AW+1)'(7);
        host_rd_req_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (host_rd_ack_o !== 1'b1 || host_rd_data_o !== 16'hABCD) begin
            errors++;
            $display("FAIL pre_reset_ack: got ack=%b %h want ack=1 abcd",
                     host_rd_ack_o, host_rd_data_o);
        end
        #1 reset_n_i = 1'b0;
        #1;
        checks++;
        if (cop_rd_data_o !== 32'h0 || cop_rd_valid_o !== 1'b0 ||
            host_rd_data_o !== 16'h0 || host_rd_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h %b %h %b want all 0",
                     cop_rd_data_o, cop_rd_valid_o,
                     host_rd_data_o, host_rd_ack_o);
        end
        host_rd_req_i = 1'b0;
        @(negedge clk);
        reset_n_i = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (host_rd_ack_o !== 1'b0) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL post_reset_ack: got %0d acks want 0", acks);
        end
        cop_rd_en_i   = 1'b1;
        cop_rd_addr_i = AW'(3);
        cop_q.push_back('{1'b1, 32'h5555ABCD});
        @(negedge clk);
        cop_rd_en_i = 1'b0;
        e = cop_q.pop_front();
        checks++;
        if (cop_rd_valid_o !== e.valid || cop_rd_data_o !== e.data) begin
            errors++;
            $display("FAIL post_reset_mem: got v=%b %h want v=%b %h",
                     cop_rd_valid_o, cop_rd_data_o, e.valid, e.data);
        end
    endtask

    task automatic test_host_info();
        int          lat;
        bit          got;
        logic [15:0] d;
        logic [15:0] x;
        @(negedge clk);
        host_addr_i   = (AW+1)'((INFO_OFF + 14) * 2);
        host_rd_req_i = 1'b1;
        host_q.push_back(XOSERA_VERSION);
        lat = 0;
        got = 1'b0;
        d   = '0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (host_rd_ack_o === 1'b1) begin
                got = 1'b1;
                d   = host_rd_data_o;
            end
        end
        host_rd_req_i = 1'b0;
        x = host_q.pop_front();
        checks++;
        if (!got || d !== x) begin
            errors++;
            $display("FAIL host_info_read: got ack=%b %h want ack=1 %h",
                     got, d, x);
        end
    endtask

    initial begin
        test_reset();
        test_info();
        test_write_fetch();
        test_host_read();
        test_forward();
        test_starve();
        test_req_drop();
        test_reset_mid();
        test_host_info();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
